// File: rtl/bus_m_arb.sv
// bus_m_arb: two-requester arbiter in front of a single bus master.
//
// Requesters S0/S1 issue commands (REQ + qualifiers + ADDR/WDATA). One is
// selected per cycle and its command is muxed onto M_* with no added latency.
// An acknowledged command with LOCK or CONT keeps that requester as owner
// until it presents a command with both cleared.
// Completions come back in order. The data-phase owner (dph_own) routes
// LAST and the raw done/rdata. The done owner (done_own) routes the
// registered DONE/RDATA that arrive one cycle after LAST.
//
// Ports
//   CLK, RES_SYS_N               clock, async active-low reset
//   Sn_REQ..Sn_WDATA (n=0,1)     requester command
//   Sn_ACK, Sn_LAST              per-requester acknowledge / last data cycle
//   Sn_RDATA, Sn_DONE            completion ({BUSERR,EXCEPTION,WRITE,DONE})
//   Sn_RDATA_RAW, Sn_DONE_RAW    raw data-phase completion
//   M_REQ..M_WDATA               command to the bus master
//   M_ACK, M_LAST, M_RDATA(_RAW), M_DONE(_RAW)  bus master responses
module bus_m_arb #(
    parameter int FIXED_PRI = 0
) (
    input  logic        CLK,
    input  logic        RES_SYS_N,
    input  logic        S0_REQ,
    input  logic        S0_SEQ,
    input  logic        S0_CONT,
    input  logic        S0_LOCK,
    input  logic        S0_WRITE,
    input  logic [2:0]  S0_BURST,
    input  logic [3:0]  S0_PROT,
    input  logic [1:0]  S0_SIZE,
    input  logic [31:0] S0_ADDR,
    input  logic [31:0] S0_WDATA,
    output logic        S0_ACK,
    output logic        S0_LAST,
    output logic [31:0] S0_RDATA,
    output logic [3:0]  S0_DONE,
    output logic [31:0] S0_RDATA_RAW,
    output logic [3:0]  S0_DONE_RAW,
    input  logic        S1_REQ,
    input  logic        S1_SEQ,
    input  logic        S1_CONT,
    input  logic        S1_LOCK,
    input  logic        S1_WRITE,
    input  logic [2:0]  S1_BURST,
    input  logic [3:0]  S1_PROT,
    input  logic [1:0]  S1_SIZE,
    input  logic [31:0] S1_ADDR,
    input  logic [31:0] S1_WDATA,
    output logic        S1_ACK,
    output logic        S1_LAST,
    output logic [31:0] S1_RDATA,
    output logic [3:0]  S1_DONE,
    output logic [31:0] S1_RDATA_RAW,
    output logic [3:0]  S1_DONE_RAW,
    output logic        M_REQ,
    output logic        M_SEQ,
    output logic        M_CONT,
    output logic        M_LOCK,
    output logic        M_WRITE,
    output logic [2:0]  M_BURST,
    output logic [3:0]  M_PROT,
    output logic [1:0]  M_SIZE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    input  logic        M_ACK,
    input  logic        M_LAST,
    input  logic [31:0] M_RDATA,
    input  logic [31:0] M_RDATA_RAW,
    input  logic [3:0]  M_DONE,
    input  logic [3:0]  M_DONE_RAW
);

    typedef enum logic [1:0] {ARB = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t state;
    logic   last_gnt;
    logic   dph_vld;
    logic   dph_own;
    logic   done_own;
    logic   sel;
    logic   hold;

    // While arbitrating, a requester dropping REQ before its ACK simply
    // changes the choice in the same cycle.
    always_comb begin
        sel = last_gnt;
        case (state)
            OWN0:    sel = 1'b0;
            OWN1:    sel = 1'b1;
            default: begin
                if (S0_REQ && !S1_REQ)      sel = 1'b0;
                else if (S1_REQ && !S0_REQ) sel = 1'b1;
                else if (S0_REQ && S1_REQ)  sel = (FIXED_PRI != 0) ? 1'b0 : ~last_gnt;
                else                        sel = last_gnt;
            end
        endcase
    end

    // Selected requester wants to keep the bus after this command.
    assign hold = sel ? (S1_LOCK | S1_CONT) : (S0_LOCK | S0_CONT);

    always_ff @(posedge CLK or negedge RES_SYS_N) begin
        if (!RES_SYS_N) begin
            state    <= ARB;
            last_gnt <= 1'b1;
            dph_vld  <= 1'b0;
            dph_own  <= 1'b0;
            done_own <= 1'b0;
        end else begin
            if (M_ACK && hold)
                state <= sel ? OWN1 : OWN0;
            else if (!hold)
                state <= ARB;

            if (M_ACK)
                last_gnt <= sel;

            // ACK opens a new data phase; a coincident LAST belongs to the
            // previous one and is routed with the old dph_own this cycle.
            if (M_ACK) begin
                dph_vld <= 1'b1;
                dph_own <= sel;
            end else if (M_LAST) begin
                dph_vld <= 1'b0;
            end

            if (M_LAST)
                done_own <= dph_own;
        end
    end

    assign M_REQ   = sel ? S1_REQ   : S0_REQ;
    assign M_SEQ   = sel ? S1_SEQ   : S0_SEQ;
    assign M_CONT  = sel ? S1_CONT  : S0_CONT;
    assign M_LOCK  = sel ? S1_LOCK  : S0_LOCK;
    assign M_WRITE = sel ? S1_WRITE : S0_WRITE;
    assign M_BURST = sel ? S1_BURST : S0_BURST;
    assign M_PROT  = sel ? S1_PROT  : S0_PROT;
    assign M_SIZE  = sel ? S1_SIZE  : S0_SIZE;
    assign M_ADDR  = sel ? S1_ADDR  : S0_ADDR;
    assign M_WDATA = sel ? S1_WDATA : S0_WDATA;

    assign S0_ACK = M_ACK & ~sel;
    assign S1_ACK = M_ACK &  sel;

    // LAST with no open data phase is dropped.
    assign S0_LAST = M_LAST & dph_vld & ~dph_own;
    assign S1_LAST = M_LAST & dph_vld &  dph_own;

    assign S0_DONE_RAW  = (dph_vld && !dph_own) ? M_DONE_RAW  : 4'd0;
    assign S1_DONE_RAW  = (dph_vld &&  dph_own) ? M_DONE_RAW  : 4'd0;
    assign S0_RDATA_RAW = (dph_vld && !dph_own) ? M_RDATA_RAW : 32'd0;
    assign S1_RDATA_RAW = (dph_vld &&  dph_own) ? M_RDATA_RAW : 32'd0;

    assign S0_DONE  = !done_own ? M_DONE  : 4'd0;
    assign S1_DONE  =  done_own ? M_DONE  : 4'd0;
    assign S0_RDATA = !done_own ? M_RDATA : 32'd0;
    assign S1_RDATA =  done_own ? M_RDATA : 32'd0;

endmodule

// File: tb/tb_bus_m_arb.sv
// Bench for bus_m_arb: a round-robin instance (k=0) and a fixed-priority
// instance (k=1) see identical stimulus; a transaction-level model per
// instance is compared with every output on each falling edge.
module tb_bus_m_arb;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    logic        s_req[2], s_seq[2], s_cont[2], s_lock[2], s_write[2];
    logic [2:0]  s_burst[2];
    logic [3:0]  s_prot[2];
    logic [1:0]  s_size[2];
    logic [31:0] s_addr[2], s_wdata[2];
    logic        m_ack, m_last;
    logic [31:0] m_rdata, m_rdata_raw;
    logic [3:0]  m_done, m_done_raw;

    logic        o_ack[2][2], o_last[2][2];
    logic [31:0] o_rdata[2][2], o_rdata_raw[2][2];
    logic [3:0]  o_done[2][2], o_done_raw[2][2];
    logic        mo_req[2], mo_seq[2], mo_cont[2], mo_lock[2], mo_write[2];
    logic [2:0]  mo_burst[2];
    logic [3:0]  mo_prot[2];
    logic [1:0]  mo_size[2];
    logic [31:0] mo_addr[2], mo_wdata[2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        bus_m_arb #(.FIXED_PRI(k)) u_dut (
            .CLK(CLK), .RES_SYS_N(rst_n),
            .S0_REQ(s_req[0]), .S0_SEQ(s_seq[0]), .S0_CONT(s_cont[0]), .S0_LOCK(s_lock[0]),
            .S0_WRITE(s_write[0]), .S0_BURST(s_burst[0]), .S0_PROT(s_prot[0]), .S0_SIZE(s_size[0]),
            .S0_ADDR(s_addr[0]), .S0_WDATA(s_wdata[0]),
            .S0_ACK(o_ack[k][0]), .S0_LAST(o_last[k][0]), .S0_RDATA(o_rdata[k][0]),
            .S0_DONE(o_done[k][0]), .S0_RDATA_RAW(o_rdata_raw[k][0]), .S0_DONE_RAW(o_done_raw[k][0]),
            .S1_REQ(s_req[1]), .S1_SEQ(s_seq[1]), .S1_CONT(s_cont[1]), .S1_LOCK(s_lock[1]),
            .S1_WRITE(s_write[1]), .S1_BURST(s_burst[1]), .S1_PROT(s_prot[1]), .S1_SIZE(s_size[1]),
            .S1_ADDR(s_addr[1]), .S1_WDATA(s_wdata[1]),
            .S1_ACK(o_ack[k][1]), .S1_LAST(o_last[k][1]), .S1_RDATA(o_rdata[k][1]),
            .S1_DONE(o_done[k][1]), .S1_RDATA_RAW(o_rdata_raw[k][1]), .S1_DONE_RAW(o_done_raw[k][1]),
            .M_REQ(mo_req[k]), .M_SEQ(mo_seq[k]), .M_CONT(mo_cont[k]), .M_LOCK(mo_lock[k]),
            .M_WRITE(mo_write[k]), .M_BURST(mo_burst[k]), .M_PROT(mo_prot[k]), .M_SIZE(mo_size[k]),
            .M_ADDR(mo_addr[k]), .M_WDATA(mo_wdata[k]),
            .M_ACK(m_ack), .M_LAST(m_last), .M_RDATA(m_rdata), .M_RDATA_RAW(m_rdata_raw),
            .M_DONE(m_done), .M_DONE_RAW(m_done_raw)
        );
    end

    int ntot = 0;
    int npass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        else
            npass++;
    endtask

    // Model: owner (-1 = nobody holds the bus), last granted requester,
    // requester whose data phase is open (-1 = none), requester of the most
    // recently acknowledged command, and requester the completion belongs to.
    int own[2], lg[2], dp[2], dp_last[2], dn[2];

    function automatic int pick(input int k);
        if (own[k] >= 0) return own[k];
        if (s_req[0] && !s_req[1]) return 0;
        if (s_req[1] && !s_req[0]) return 1;
        if (s_req[0] && s_req[1]) return (k == 1) ? 0 : 1 - lg[k];
        return lg[k];
    endfunction

    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            int s;
            if (!rst_n) begin
                own[k] = -1; lg[k] = 1; dp[k] = -1; dp_last[k] = 0; dn[k] = 0;
            end
            s = pick(k);
            chk($sformatf("k%0d m_cmd", k),
                {18'd0, mo_req[k], mo_seq[k], mo_cont[k], mo_lock[k], mo_write[k],
                 mo_burst[k], mo_prot[k], mo_size[k]},
                {18'd0, s_req[s], s_seq[s], s_cont[s], s_lock[s], s_write[s],
                 s_burst[s], s_prot[s], s_size[s]});
            chk($sformatf("k%0d m_addr", k), mo_addr[k], s_addr[s]);
            chk($sformatf("k%0d m_wdata", k), mo_wdata[k], s_wdata[s]);
            for (int n = 0; n < 2; n++) begin
                chk($sformatf("k%0d s%0d_ack", k, n), 32'(o_ack[k][n]), 32'(m_ack && s == n));
                chk($sformatf("k%0d s%0d_last", k, n), 32'(o_last[k][n]), 32'(m_last && dp[k] == n));
                chk($sformatf("k%0d s%0d_done_raw", k, n), 32'(o_done_raw[k][n]),
                    32'((dp[k] == n) ? m_done_raw : 4'd0));
                chk($sformatf("k%0d s%0d_rdata_raw", k, n), o_rdata_raw[k][n],
                    (dp[k] == n) ? m_rdata_raw : 32'd0);
                chk($sformatf("k%0d s%0d_done", k, n), 32'(o_done[k][n]),
                    32'((dn[k] == n) ? m_done : 4'd0));
                chk($sformatf("k%0d s%0d_rdata", k, n), o_rdata[k][n],
                    (dn[k] == n) ? m_rdata : 32'd0);
            end
            if (rst_n) begin
                if (m_last) dn[k] = dp_last[k];
                if (m_ack) begin
                    dp[k] = s; dp_last[k] = s; lg[k] = s;
                end else if (m_last) begin
                    dp[k] = -1;
                end
                if (m_ack && (s_lock[s] || s_cont[s])) own[k] = s;
                else if (!(s_lock[s] || s_cont[s])) own[k] = -1;
            end
        end
    end

    task automatic half(); @(negedge CLK); #1; endtask
    task automatic adv();  @(posedge CLK); #1; endtask

    task automatic l_ack(input int n, input logic e);
        for (int k = 0; k < 2; k++) chk($sformatf("lit k%0d s%0d_ack", k, n), 32'(o_ack[k][n]), 32'(e));
    endtask
    task automatic l_last(input int n, input logic e);
        for (int k = 0; k < 2; k++) chk($sformatf("lit k%0d s%0d_last", k, n), 32'(o_last[k][n]), 32'(e));
    endtask
    task automatic l_done(input int n, input logic [3:0] e);
        for (int k = 0; k < 2; k++) chk($sformatf("lit k%0d s%0d_done", k, n), 32'(o_done[k][n]), 32'(e));
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            s_req[n] = 0; s_seq[n] = 0; s_cont[n] = 0; s_lock[n] = 0; s_write[n] = 0;
        end
        s_burst[0] = 3'd1; s_burst[1] = 3'd3;
        s_prot[0]  = 4'd2; s_prot[1]  = 4'd5;
        s_size[0]  = 2'd1; s_size[1]  = 2'd2;
        s_seq[0]   = 1'b1;
        s_addr[0]  = 32'h100;      s_addr[1]  = 32'h200;
        s_wdata[0] = 32'hAAAA0000; s_wdata[1] = 32'h5555FFFF;
        m_ack = 0; m_rdata = 32'h0; m_rdata_raw = 32'h0; m_done_raw = 4'd0;

        // reset: S0 passes M_DONE through, S1 and LAST stay quiet
        m_last = 1; m_done = 4'b0101; s_req[1] = 1;
        half();
        l_done(0, 4'b0101); l_done(1, 4'd0); l_last(0, 0); l_last(1, 0);
        adv();
        rst_n = 1; m_last = 0; m_done = 4'd0; s_req[1] = 0;

        // both request, ACK every cycle: RR alternates from S0, fixed stays on S0
        s_req[0] = 1; s_req[1] = 1; m_ack = 1; m_rdata_raw = 32'h1234;
        for (int i = 0; i < 4; i++) begin
            half();
            chk($sformatf("lit rr s0_ack #%0d", i), 32'(o_ack[0][0]), 32'(i % 2 == 0));
            chk($sformatf("lit rr s1_ack #%0d", i), 32'(o_ack[0][1]), 32'(i % 2 == 1));
            chk($sformatf("lit fx s0_ack #%0d", i), 32'(o_ack[1][0]), 32'd1);
            chk($sformatf("lit fx s1_ack #%0d", i), 32'(o_ack[1][1]), 32'd0);
            if (i == 0) chk("lit rr first m_addr", mo_addr[0], 32'h100);
            adv();
        end
        s_req[0] = 0;
        half(); chk("lit fx s1_ack after s0 drops", 32'(o_ack[1][1]), 32'd1); adv();
        m_ack = 0; s_req[1] = 0; m_rdata_raw = 32'h0;
        half(); adv();

        // S1 locks for 3 transfers while S0 waits, then S0 gets the bus
        s_req[1] = 1; s_lock[1] = 1; m_ack = 1;
        half(); l_ack(1, 1); adv();
        s_req[0] = 1;
        for (int i = 0; i < 2; i++) begin
            half(); l_ack(0, 0); l_ack(1, 1); adv();
        end
        s_lock[1] = 0;
        half(); l_ack(0, 0); l_ack(1, 1); adv();
        half(); l_ack(0, 1); adv();
        m_ack = 0; s_req[0] = 0; s_req[1] = 0;
        half(); adv();

        // S0 read, then S1 write whose ACK coincides with S0's LAST
        s_req[0] = 1; s_write[0] = 0; m_ack = 1;
        half(); l_ack(0, 1); adv();
        s_req[0] = 0; s_req[1] = 1; s_write[1] = 1; m_last = 1;
        half(); l_last(0, 1); l_last(1, 0); l_ack(1, 1); adv();
        s_req[1] = 0; m_ack = 0; m_last = 0; m_done = 4'b0001; m_rdata = 32'hCAFE0123;
        half();
        l_done(0, 4'b0001); l_done(1, 4'd0);
        for (int k = 0; k < 2; k++) chk($sformatf("lit k%0d s0_rdata", k), o_rdata[k][0], 32'hCAFE0123);
        adv();
        m_done = 4'd0; m_rdata = 32'h0; m_last = 1;
        half(); l_last(1, 1); l_last(0, 0); adv();
        m_last = 0; m_done = 4'b0011;
        half(); l_done(1, 4'b0011); l_done(0, 4'd0); adv();
        m_done = 4'd0; s_write[1] = 0;

        // S1 read ending in bus error
        s_req[1] = 1; m_ack = 1;
        half(); adv();
        s_req[1] = 0; m_ack = 0; m_last = 1; m_done_raw = 4'b1001; m_rdata_raw = 32'hBEEF;
        half();
        l_last(1, 1);
        for (int k = 0; k < 2; k++) chk($sformatf("lit k%0d s1_done_raw", k), 32'(o_done_raw[k][1]), 32'h9);
        adv();
        m_last = 0; m_done_raw = 4'd0; m_rdata_raw = 32'h0; m_done = 4'b1001;
        half(); l_done(1, 4'b1001); l_done(0, 4'd0); adv();
        m_done = 4'd0;

        // LAST with no open data phase goes nowhere
        m_last = 1;
        half(); l_last(0, 0); l_last(1, 0); adv();
        m_last = 0;

        // reset while S1 owns the bus with a data phase open
        s_req[1] = 1; s_lock[1] = 1; m_ack = 1;
        half(); adv();
        for (int k = 0; k < 2; k++) chk($sformatf("lit k%0d owned m_addr", k), mo_addr[k], 32'h200);
        rst_n = 0; m_ack = 0; m_last = 1; s_req[0] = 1;
        #1;
        l_last(1, 0); l_last(0, 0);
        for (int k = 0; k < 2; k++) chk($sformatf("lit k%0d reset m_addr", k), mo_addr[k], 32'h100);
        half(); adv();
        rst_n = 1; m_last = 0; s_lock[1] = 0; m_ack = 1;
        half(); l_ack(0, 1); l_ack(1, 0); adv();
        m_ack = 0; s_req[0] = 0; s_req[1] = 0;
        half(); adv();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
